// File: rtl/de_regfile_scoreboard_if.sv
// DE-stage register file / scoreboard bundle: read ports, issue handshake, WB write port, flush and error.
// master = DE control / bench side, slave = de_regfile_scoreboard.
interface de_regfile_scoreboard_if #(
  parameter int DBITS     = 32,
  parameter int REGNOBITS = 5,
  parameter int NRD       = 2
);
  logic [NRD*REGNOBITS-1:0] rd_regno;
  logic [NRD-1:0]           rd_en;
  logic [NRD*DBITS-1:0]     rd_val;
  logic                     iss_valid;
  logic                     iss_wr;
  logic [REGNOBITS-1:0]     iss_regno;
  logic                     iss_ready;
  logic                     stall;
  logic                     wb_wr;
  logic [REGNOBITS-1:0]     wb_regno;
  logic [DBITS-1:0]         wb_val;
  logic                     flush;
  logic                     err_uflow;

  modport master (
    output rd_regno, rd_en, iss_valid, iss_wr, iss_regno, wb_wr, wb_regno, wb_val, flush,
    input  rd_val, iss_ready, stall, err_uflow
  );

  modport slave (
    input  rd_regno, rd_en, iss_valid, iss_wr, iss_regno, wb_wr, wb_regno, wb_val, flush,
    output rd_val, iss_ready, stall, err_uflow
  );
endinterface

// File: rtl/de_regfile_scoreboard.sv
// DE-stage register file with per-register counted pending writes (replaces fixed stage-compare stalls).
// Optional WB->DE same-cycle bypass is enabled by defining DE_WB_BYPASS_EN.
module de_regfile_scoreboard #(
  parameter int DBITS     = 32,
  parameter int REGWORDS  = 32,
  parameter int REGNOBITS = 5,
  parameter int NRD       = 2,
  parameter int CNTBITS   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  de_regfile_scoreboard_if.slave bus
);
  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  logic [DBITS-1:0]     regs [REGWORDS];
  logic [CNTBITS-1:0]   pend [REGWORDS];
  logic                 err_q;

  logic [REGNOBITS-1:0] rd_no [NRD];
  logic [NRD-1:0]       byp_ok;
  logic [NRD-1:0]       port_haz;
  logic [NRD*DBITS-1:0] rd_val_c;
  logic                 struct_blk;
  logic                 ready_c;
  logic                 fire;
  logic [REGWORDS-1:0]  inc_vec;
  logic [REGWORDS-1:0]  dec_vec;

  always_comb begin
    rd_no    = '{default: '0};
    byp_ok   = '0;
    port_haz = '0;
    rd_val_c = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_no[i] = bus.rd_regno[i*REGNOBITS +: REGNOBITS];
`ifdef DE_WB_BYPASS_EN
      byp_ok[i] = bus.wb_wr && (bus.wb_regno == rd_no[i]) && (pend[rd_no[i]] == CNTBITS'(1));
`else
      byp_ok[i] = 1'b0;
`endif
      if (rd_no[i] != '0)
        rd_val_c[i*DBITS +: DBITS] = byp_ok[i] ? bus.wb_val : regs[rd_no[i]];
      port_haz[i] = bus.rd_en[i] && (rd_no[i] != '0) && (pend[rd_no[i]] != '0) && !byp_ok[i];
    end
  end

  // A retiring write to the saturated register frees a slot in the same cycle.
  assign struct_blk = bus.iss_wr && (bus.iss_regno != '0) && (pend[bus.iss_regno] == CNT_MAX)
                      && !(bus.wb_wr && (bus.wb_regno == bus.iss_regno));

  assign ready_c       = !reset && !bus.flush && !(|port_haz) && !struct_blk;
  assign fire          = bus.iss_valid && ready_c;
  assign bus.iss_ready = ready_c;
  assign bus.stall     = bus.iss_valid && !ready_c && !reset;
  assign bus.rd_val    = rd_val_c;
  assign bus.err_uflow = err_q;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < REGWORDS; r++) begin
      inc_vec[r] = fire && bus.iss_wr && (bus.iss_regno == REGNOBITS'(r));
      dec_vec[r] = bus.wb_wr && (bus.wb_regno == REGNOBITS'(r));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REGWORDS; r++) regs[r] <= '0;
    end else if (bus.wb_wr && (bus.wb_regno != '0)) begin
      regs[bus.wb_regno] <= bus.wb_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REGWORDS; r++) pend[r] <= '0;
      err_q <= 1'b0;
    end else begin
      if (bus.wb_wr && (bus.wb_regno != '0) && (pend[bus.wb_regno] == '0))
        err_q <= 1'b1;
      for (int r = 1; r < REGWORDS; r++) begin
        if (bus.flush)
          pend[r] <= '0;
        else if (inc_vec[r] && !dec_vec[r])
          pend[r] <= pend[r] + 1'b1;
        else if (dec_vec[r] && !inc_vec[r] && (pend[r] != '0))
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end
endmodule
